// File: rtl/uart_frame_loader_pkg.sv
// ============================================================================
// Module   : uart_frame_loader_pkg
// Brief    : Shared frame protocol constants, default frame geometry, FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_frame_loader_pkg;

    localparam logic [7:0] SYNC0 = 8'hAA;
    localparam logic [7:0] SYNC1 = 8'h55;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    // Geometry shared with the frame-RAM controller (128x128 RGB332)
    localparam int unsigned DEF_PIX_NUM     = 16384;
    localparam int unsigned DEF_ADDR_W      = 14;
    localparam int unsigned DEF_TIMEOUT_CYC = 5_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_PIXEL = 2'd2,
        ST_CSUM  = 2'd3
    } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_timeout.sv
// ============================================================================
// Module   : uart_byte_timeout
// Brief    : Inter-byte idle counter; pulses o_term on the cycle it would reach TIMEOUT_CYC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_timeout #(
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_term
);

    localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_term_val = c_cnt_w'(TIMEOUT_CYC - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // A clear in the terminal cycle suppresses the pulse: the byte wins.
    assign o_term = i_en && !i_clr && (r_cnt == c_term_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || o_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_frame_loader.sv
// ============================================================================
// Module   : uart_frame_loader
// Brief    : UART byte-stream framer: sync hunt, pixel writes, checksum, ACK/NAK.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int unsigned PIX_NUM     = DEF_PIX_NUM,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              pi_flag,
    input  logic [7:0]        pi_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic              tx_flag,
    output logic [7:0]        tx_data
);

    localparam logic [ADDR_W:0] c_last_pix = (ADDR_W + 1)'(PIX_NUM - 1);

    frame_state_t      r_state,   w_state_nxt;
    logic [ADDR_W:0]   r_pix_cnt, w_pix_cnt_nxt;
    logic [7:0]        r_sum,     w_sum_nxt;
    logic              r_wr_en,   w_wr_en_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0]        r_wr_data, w_wr_data_nxt;
    logic              r_busy,    w_busy_nxt;
    logic              r_done,    w_done_nxt;
    logic              r_err,     w_err_nxt;
    logic              r_tx_flag, w_tx_flag_nxt;
    logic [7:0]        r_tx_data, w_tx_data_nxt;

    logic w_in_frame;
    logic w_to_clr;
    logic w_timeout;

    assign w_in_frame = (r_state != ST_IDLE);
    assign w_to_clr   = pi_flag || (r_state == ST_IDLE);

    uart_byte_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (sclk),
        .rst    (rst),
        .i_en   (w_in_frame),
        .i_clr  (w_to_clr),
        .o_term (w_timeout)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_pix_cnt_nxt = r_pix_cnt;
        w_sum_nxt     = r_sum;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_tx_flag_nxt = 1'b0;
        w_tx_data_nxt = r_tx_data;

        if (w_timeout) begin
            w_state_nxt   = ST_IDLE;
            w_busy_nxt    = 1'b0;
            w_err_nxt     = 1'b1;
            w_tx_flag_nxt = 1'b1;
            w_tx_data_nxt = NAK;
        end else if (pi_flag) begin
            case (r_state)
                ST_IDLE: begin
                    if (pi_data == SYNC0) begin
                        w_state_nxt = ST_HDR;
                    end
                end
                ST_HDR: begin
                    // A repeated SYNC0 may be the real start of the header.
                    if (pi_data == SYNC1) begin
                        w_state_nxt   = ST_PIXEL;
                        w_pix_cnt_nxt = '0;
                        w_sum_nxt     = '0;
                        w_busy_nxt    = 1'b1;
                    end else if (pi_data != SYNC0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_PIXEL: begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_pix_cnt[ADDR_W-1:0];
                    w_wr_data_nxt = pi_data;
                    w_sum_nxt     = r_sum + pi_data;
                    w_pix_cnt_nxt = r_pix_cnt + 1'b1;
                    if (r_pix_cnt == c_last_pix) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    w_state_nxt   = ST_IDLE;
                    w_busy_nxt    = 1'b0;
                    w_tx_flag_nxt = 1'b1;
                    if (pi_data == r_sum) begin
                        w_done_nxt    = 1'b1;
                        w_tx_data_nxt = ACK;
                    end else begin
                        w_err_nxt     = 1'b1;
                        w_tx_data_nxt = NAK;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pix_cnt <= '0;
            r_sum     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_tx_flag <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pix_cnt <= w_pix_cnt_nxt;
            r_sum     <= w_sum_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_tx_flag <= w_tx_flag_nxt;
            r_tx_data <= w_tx_data_nxt;
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign tx_flag    = r_tx_flag;
    assign tx_data    = r_tx_data;

endmodule

`default_nettype wire
